operand_capture: RTL and testbench

- Input-conditioning stage directly upstream of the calculator top level; replaces raw board switches as the source of inputA/inputB/signAb/signBb/op.
- Synchronises the slide switches and debounces two push-buttons (enter, clear).
- Sequences entry of operand A, operand B and operator, holding each in a register so the display and calculator see stable values.
- Raises result_valid once all three fields are captured.

---
 rtl/operand_capture_pkg.sv | 26 ++
 rtl/operand_capture_button_debounce.sv | 55 +++++
 rtl/operand_capture.sv | 168 ++++++++++++++++
 tb/tb_operand_capture.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_capture_pkg.sv
// Shared definitions for the calculator operand-entry front end:
// entry states, operator codes and default timing constants.
package operand_capture_pkg;

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        ENTER_OP = 2'd2,
        SHOW     = 2'd3
    } entry_state_e;

    // Operator codes as decoded by the calculator top level
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_CNT_W           = 20;
    localparam int DEFAULT_MAX_OPERAND     = 15;

    function automatic logic [3:0] saturateMag(input logic [3:0] value, input logic [3:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/operand_capture_button_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// single-cycle pulse on each accepted rising level.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw_i,
    output logic pulse_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             syncMeta_q;
    logic             syncLevel_q;
    logic             stable_q;
    logic             stable_d;
    logic             stableDly_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The counter only runs while the synchronised level disagrees with the accepted one
    always_comb begin
        count_d  = count_q;
        stable_d = stable_q;
        if (syncLevel_q == stable_q) begin
            count_d = '0;
        end else if (count_q == CNT_LAST) begin
            stable_d = syncLevel_q;
            count_d  = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            syncMeta_q  <= 1'b0;
            syncLevel_q <= 1'b0;
            stable_q    <= 1'b0;
            stableDly_q <= 1'b0;
            count_q     <= '0;
        end else begin
            syncMeta_q  <= btn_raw_i;
            syncLevel_q <= syncMeta_q;
            stable_q    <= stable_d;
            stableDly_q <= stable_q;
            count_q     <= count_d;
        end
    end

    assign pulse_o = stable_q & ~stableDly_q;

endmodule

// File: rtl/operand_capture.sv
// Operand entry sequencer: captures A, B and the operator on debounced enter
// presses and holds them stable for the display and calculator.
module operand_capture
    import operand_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W,
    parameter int MAX_OPERAND     = DEFAULT_MAX_OPERAND
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] sw_value,
    input  logic       sw_sign,
    input  logic [1:0] sw_op,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [3:0] inputA,
    output logic       signA,
    output logic [3:0] inputB,
    output logic       signB,
    output logic [1:0] op,
    output logic [1:0] entry_state,
    output logic       result_valid,
    output logic       capture_pulse
);

    localparam logic [3:0] MAX_MAG = 4'(MAX_OPERAND);

    logic [6:0]   swMeta_q;
    logic [6:0]   swSync_q;
    logic [3:0]   swValue;
    logic         swSign;
    logic [1:0]   swOp;
    logic         enterPulse;
    logic         clearPulse;

    entry_state_e state_q;
    entry_state_e state_d;
    logic [3:0]   inputA_q, inputA_d;
    logic         signA_q, signA_d;
    logic [3:0]   inputB_q, inputB_d;
    logic         signB_q, signB_d;
    logic [1:0]   op_q, op_d;
    logic         resultValid_q, resultValid_d;
    logic         capturePulse_q, capturePulse_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            swMeta_q <= '0;
            swSync_q <= '0;
        end else begin
            swMeta_q <= {sw_value, sw_sign, sw_op};
            swSync_q <= swMeta_q;
        end
    end

    assign swValue = swSync_q[6:3];
    assign swSign  = swSync_q[2];
    assign swOp    = swSync_q[1:0];

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_enter (
        .clock    (clock),
        .reset    (reset),
        .btn_raw_i(btn_enter),
        .pulse_o  (enterPulse)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_clear (
        .clock    (clock),
        .reset    (reset),
        .btn_raw_i(btn_clear),
        .pulse_o  (clearPulse)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ENTER_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear has priority over enter when both pulses land together
    always_comb begin
        state_d = state_q;
        if (clearPulse) begin
            state_d = ENTER_A;
        end else if (enterPulse) begin
            case (state_q)
                ENTER_A:  state_d = ENTER_B;
                ENTER_B:  state_d = ENTER_OP;
                ENTER_OP: state_d = SHOW;
                default:  state_d = ENTER_A;
            endcase
        end
    end

    always_comb begin
        inputA_d       = inputA_q;
        signA_d        = signA_q;
        inputB_d       = inputB_q;
        signB_d        = signB_q;
        op_d           = op_q;
        capturePulse_d = 1'b0;
        if (clearPulse) begin
            inputA_d = '0;
            signA_d  = 1'b0;
            inputB_d = '0;
            signB_d  = 1'b0;
            op_d     = '0;
        end else if (enterPulse) begin
            case (state_q)
                ENTER_A: begin
                    inputA_d       = saturateMag(swValue, MAX_MAG);
                    signA_d        = swSign;
                    capturePulse_d = 1'b1;
                end
                ENTER_B: begin
                    inputB_d       = saturateMag(swValue, MAX_MAG);
                    signB_d        = swSign;
                    capturePulse_d = 1'b1;
                end
                ENTER_OP: begin
                    op_d           = swOp;
                    capturePulse_d = 1'b1;
                end
                default: ;
            endcase
        end
        resultValid_d = (state_d == SHOW);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inputA_q       <= '0;
            signA_q        <= 1'b0;
            inputB_q       <= '0;
            signB_q        <= 1'b0;
            op_q           <= '0;
            resultValid_q  <= 1'b0;
            capturePulse_q <= 1'b0;
        end else begin
            inputA_q       <= inputA_d;
            signA_q        <= signA_d;
            inputB_q       <= inputB_d;
            signB_q        <= signB_d;
            op_q           <= op_d;
            resultValid_q  <= resultValid_d;
            capturePulse_q <= capturePulse_d;
        end
    end

    assign inputA        = inputA_q;
    assign signA         = signA_q;
    assign inputB        = inputB_q;
    assign signB         = signB_q;
    assign op            = op_q;
    assign entry_state   = state_q;
    assign result_valid  = resultValid_q;
    assign capture_pulse = capturePulse_q;

endmodule

// File: tb/tb_operand_capture.sv
// Self-checking bench for operand_capture with a short debounce window and
// a reduced saturation limit, compared against an entry-sequence model.
module tb_operand_capture;

    localparam int DEB   = 4;
    localparam int MAXOP = 9;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] sw_value = '0;
    logic       sw_sign = 1'b0;
    logic [1:0] sw_op = '0;
    logic       btn_enter = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] inputA;
    logic       signA;
    logic [3:0] inputB;
    logic       signB;
    logic [1:0] op;
    logic [1:0] entry_state;
    logic       result_valid;
    logic       capture_pulse;

    int assertCount = 0;
    int failCount   = 0;
    int capSeen     = 0;

    // Behavioural model of the entry sequence: step 0..3 = A, B, operator, show
    int         expStep = 0;
    int         expCaps = 0;
    int         expA = 0, expB = 0, expOp = 0;
    logic       expSA = 1'b0, expSB = 1'b0;
    int         curVal = 0, curOp = 0;
    logic       curSign = 1'b0;

    operand_capture #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3),
        .MAX_OPERAND    (MAXOP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sw_value     (sw_value),
        .sw_sign      (sw_sign),
        .sw_op        (sw_op),
        .btn_enter    (btn_enter),
        .btn_clear    (btn_clear),
        .inputA       (inputA),
        .signA        (signA),
        .inputB       (inputB),
        .signB        (signB),
        .op           (op),
        .entry_state  (entry_state),
        .result_valid (result_valid),
        .capture_pulse(capture_pulse)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (capture_pulse === 1'b1) capSeen++;
    end

    wire [14:0] obsVec = {inputA, signA, inputB, signB, op, entry_state, result_valid};

    function automatic logic [14:0] expVec();
        logic [3:0] a, b;
        logic [1:0] o, s;
        a = 4'(expA);
        b = 4'(expB);
        o = 2'(expOp);
        s = 2'(expStep);
        return {a, expSA, b, expSB, o, s, (expStep == 3)};
    endfunction

    task automatic modelReset();
        expStep = 0; expA = 0; expB = 0; expOp = 0; expSA = 0; expSB = 0;
    endtask

    task automatic modelEnter();
        case (expStep)
            0: begin expA = (curVal > MAXOP) ? MAXOP : curVal; expSA = curSign; expCaps++; end
            1: begin expB = (curVal > MAXOP) ? MAXOP : curVal; expSB = curSign; expCaps++; end
            2: begin expOp = curOp; expCaps++; end
            default: ;
        endcase
        expStep = (expStep + 1) % 4;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic setSwitches(input int v, input logic s, input int o);
        curVal = v; curSign = s; curOp = o;
        sw_value = 4'(v); sw_sign = s; sw_op = 2'(o);
    endtask

    task automatic pressEnter();
        btn_enter = 1'b1;
        waitCycles(12);
        btn_enter = 1'b0;
        waitCycles(12);
        modelEnter();
    endtask

    task automatic pressClear();
        btn_clear = 1'b1;
        waitCycles(12);
        btn_clear = 1'b0;
        waitCycles(12);
        modelReset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        setSwitches(11, 1'b1, 3);
        waitCycles(3);
        modelReset();
        assertCount++;
        if (obsVec !== expVec()) begin
            failCount++; $display("[TB] FAIL reset_outputs: got %h expected %h", obsVec, expVec());
        end
        assertCount++;
        if (capture_pulse !== 1'b0) begin
            failCount++; $display("[TB] FAIL reset_capture: got %b expected 0", capture_pulse);
        end
        reset = 1'b0;
        waitCycles(4);
        assertCount++;
        if (obsVec !== expVec()) begin
            failCount++; $display("[TB] FAIL post_reset_outputs: got %h expected %h", obsVec, expVec());
        end
    endtask

    task automatic test_full_sequence();
        int base;
        base = capSeen;
        setSwitches(5, 1'b1, 0);
        pressEnter();
        assertCount++;
        if (obsVec !== expVec()) begin
            failCount++; $display("[TB] FAIL full_seq_A: got %h expected %h", obsVec, expVec());
        end
        setSwitches(3, 1'b0, 0);
        pressEnter();
        assertCount++;
        if (obsVec !== expVec()) begin
            failCount++; $display("[TB] FAIL full_seq_B: got %h expected %h", obsVec, expVec());
        end
        setSwitches(0, 1'b0, 2);
        pressEnter();
        assertCount++;
        if (obsVec !== 15'({4'd5, 1'b1, 4'd3, 1'b0, 2'd2, 2'd3, 1'b1})) begin
            failCount++; $display("[TB] FAIL full_seq_show: got %h expected %h", obsVec,
                                  15'({4'd5, 1'b1, 4'd3, 1'b0, 2'd2, 2'd3, 1'b1}));
        end
        assertCount++;
        if (capSeen - base !== 3) begin
            failCount++; $display("[TB] FAIL full_seq_strobes: got %0d expected 3", capSeen - base);
        end
    endtask

    task automatic test_random();
        int base;
        base = capSeen;
        pressEnter();
        for (int r = 0; r < 6; r++) begin
            setSwitches(int'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)));
            pressEnter();
            assertCount++;
            if (obsVec !== expVec()) begin
                failCount++; $display("[TB] FAIL random_capture_%0d: got %h expected %h", r, obsVec, expVec());
            end
            // Switches move between captures; outputs must not follow them
            setSwitches(int'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)));
            waitCycles(6);
            assertCount++;
            if (obsVec !== expVec()) begin
                failCount++; $display("[TB] FAIL random_hold_%0d: got %h expected %h", r, obsVec, expVec());
            end
        end
        assertCount++;
        if (capSeen - base !== expCaps - 3) begin
            failCount++; $display("[TB] FAIL random_strobes: got %0d expected %0d", capSeen - base, expCaps - 3);
        end
    endtask

    task automatic test_bounce_saturation();
        int base;
        int firstHit;
        pressClear();
        setSwitches(14, 1'b1, 1);
        base = capSeen;
        for (int i = 0; i < 10; i++) begin
            btn_enter = (i % 2 == 0);
            waitCycles(2);
        end
        assertCount++;
        if (capSeen - base !== 0) begin
            failCount++; $display("[TB] FAIL bounce_no_early: got %0d captures expected 0", capSeen - base);
        end
        btn_enter = 1'b1;
        firstHit = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (capture_pulse === 1'b1 && firstHit == 0) firstHit = k;
        end
        btn_enter = 1'b0;
        waitCycles(12);
        modelEnter();
        assertCount++;
        if (firstHit !== DEB + 3) begin
            failCount++; $display("[TB] FAIL bounce_latency: got %0d cycles expected %0d", firstHit, DEB + 3);
        end
        assertCount++;
        if (capSeen - base !== 1) begin
            failCount++; $display("[TB] FAIL bounce_single: got %0d captures expected 1", capSeen - base);
        end
        assertCount++;
        if (obsVec !== expVec() || inputA !== 4'(MAXOP)) begin
            failCount++; $display("[TB] FAIL saturation: got %h expected %h", obsVec, expVec());
        end
    endtask

    task automatic test_clear_priority();
        int base;
        pressClear();
        setSwitches(7, 1'b0, 0);
        pressEnter();
        assertCount++;
        if (obsVec !== expVec()) begin
            failCount++; $display("[TB] FAIL clear_setup: got %h expected %h", obsVec, expVec());
        end
        base = capSeen;
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        waitCycles(12);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        waitCycles(12);
        modelReset();
        assertCount++;
        if (obsVec !== expVec()) begin
            failCount++; $display("[TB] FAIL clear_priority: got %h expected %h", obsVec, expVec());
        end
        assertCount++;
        if (capSeen - base !== 0) begin
            failCount++; $display("[TB] FAIL clear_no_capture: got %0d expected 0", capSeen - base);
        end
    endtask

    task automatic test_reset_mid_entry();
        int base;
        setSwitches(2, 1'b1, 0);
        pressEnter();
        setSwitches(4, 1'b0, 3);
        pressEnter();
        assertCount++;
        if (obsVec !== expVec() || entry_state !== 2'd2) begin
            failCount++; $display("[TB] FAIL midentry_setup: got %h expected %h", obsVec, expVec());
        end
        base = capSeen;
        btn_enter = 1'b1;
        waitCycles(3);
        #2 reset = 1'b1;
        #1;
        assertCount++;
        if (obsVec !== 15'd0 || capture_pulse !== 1'b0) begin
            failCount++; $display("[TB] FAIL async_reset: got %h/%b expected 0/0", obsVec, capture_pulse);
        end
        waitCycles(3);
        reset = 1'b0;
        modelReset();
        waitCycles(15);
        modelEnter();
        assertCount++;
        if (capSeen - base !== 1) begin
            failCount++; $display("[TB] FAIL reset_held_capture: got %0d expected 1", capSeen - base);
        end
        assertCount++;
        if (obsVec !== expVec()) begin
            failCount++; $display("[TB] FAIL reset_held_values: got %h expected %h", obsVec, expVec());
        end
        btn_enter = 1'b0;
        waitCycles(12);
    endtask

    task automatic test_hold_release();
        int base;
        setSwitches(12, 1'b1, 0);
        pressEnter();
        setSwitches(0, 1'b0, 1);
        pressEnter();
        assertCount++;
        if (obsVec !== expVec() || result_valid !== 1'b1) begin
            failCount++; $display("[TB] FAIL hold_show: got %h expected %h", obsVec, expVec());
        end
        base = capSeen;
        btn_enter = 1'b1;
        waitCycles(100);
        modelEnter();
        assertCount++;
        if (obsVec !== expVec()) begin
            failCount++; $display("[TB] FAIL hold_single_step: got %h expected %h", obsVec, expVec());
        end
        btn_enter = 1'b0;
        waitCycles(20);
        assertCount++;
        if (obsVec !== expVec()) begin
            failCount++; $display("[TB] FAIL release_no_step: got %h expected %h", obsVec, expVec());
        end
        assertCount++;
        if (capSeen - base !== 0) begin
            failCount++; $display("[TB] FAIL show_exit_no_strobe: got %0d expected 0", capSeen - base);
        end
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_random();
        test_bounce_saturation();
        test_clear_priority();
        test_reset_mid_entry();
        test_hold_release();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
